// File: rtl/spectrum_disp_pkg.sv
// Shared constants and frame FSM state type for the spectrum bar display.
package spectrum_disp_pkg;

    localparam int NUM_BANDS = 8;
    localparam int BAND_W    = 12;
    localparam int LEVEL_W   = 5;
    localparam int PACKED_W  = 96;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_UPDATE
    } frame_state_e;

endpackage

// File: rtl/spectrum_peak_hold.sv
// Per-band peak-hold registers with a free-running decay divider.
// Only instantiated when SPECTRUM_PEAK_HOLD_EN is defined.
module spectrum_peak_hold
    import spectrum_disp_pkg::*;
#(
    parameter int DECAY_DIV = 2500000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                update,
    input  logic [NUM_BANDS-1:0][LEVEL_W-1:0]   lvl_nxt,
    output logic [NUM_BANDS-1:0][LEVEL_W-1:0]   peak_nxt
);

    localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    logic [DW-1:0]                      decay_cnt;
    logic                               tick;
    logic [NUM_BANDS-1:0][LEVEL_W-1:0]  peak_q;

    assign tick = (decay_cnt == DW'(DECAY_DIV - 1));

    // A raise at UPDATE beats a coincident decay tick for that band.
    always_comb begin
        peak_nxt = peak_q;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (update && (lvl_nxt[b] > peak_q[b]))
                peak_nxt[b] = lvl_nxt[b];
            else if (tick && (peak_q[b] > lvl_nxt[b]))
                peak_nxt[b] = peak_q[b] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decay_cnt <= '0;
            peak_q    <= '0;
        end else begin
            decay_cnt <= tick ? '0 : decay_cnt + 1'b1;
            peak_q    <= peak_nxt;
        end
    end

endmodule

// File: rtl/spectrum_bar_display.sv
// Quantises 8 spectrum bands to bar heights and drives a column-scanned LED matrix.
// Define SPECTRUM_PEAK_HOLD_EN to overlay a decaying peak-hold dot per column.
module spectrum_bar_display
    import spectrum_disp_pkg::*;
#(
    parameter int ROWS        = 16,
    parameter int LEVEL_SHIFT = 8,
    parameter int SCAN_DIV    = 1000,
    parameter int DECAY_DIV   = 2500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PACKED_W-1:0]         spectrum_data_packed,
    input  logic                        spectrum_valid,
    input  logic                        overrun_clr,
    output logic [NUM_BANDS-1:0]        col_sel,
    output logic [ROWS-1:0]             row_data,
    output logic [NUM_BANDS*LEVEL_W-1:0] levels_packed,
    output logic                        update_done,
    output logic                        busy,
    output logic                        overrun
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (ROWS < 1 || ROWS > 31 || SCAN_DIV < 1 || DECAY_DIV < 1) begin : g_bad_param
        $error("spectrum_bar_display: illegal parameter value");
    end

    frame_state_e                       state, state_nxt;
    logic [NUM_BANDS-1:0][BAND_W-1:0]   cap_q, pend_q;
    logic                               pend_vld;
    logic [2:0]                         band_idx;
    logic [NUM_BANDS-1:0][LEVEL_W-1:0]  shadow_q, lvl_q, lvl_nxt, peak_nxt;
    logic                               start_pend, pend_wr, ovr_set;
    logic [SW-1:0]                      scan_cnt;
    logic [2:0]                         col_idx, col_nxt;
    logic [ROWS-1:0]                    row_nxt;

    function automatic logic [LEVEL_W-1:0] quantise(input logic [BAND_W-1:0] b);
        logic [BAND_W-1:0] s;
        s = b >> LEVEL_SHIFT;
        return (s > BAND_W'(ROWS)) ? LEVEL_W'(ROWS) : s[LEVEL_W-1:0];
    endfunction

    assign busy          = (state != ST_IDLE);
    assign levels_packed = lvl_q;
    assign col_sel       = 8'b1 << col_idx;
    assign lvl_nxt       = (state == ST_UPDATE) ? shadow_q : lvl_q;

    // A pending frame is consumed in UPDATE, or in IDLE if it arrived during UPDATE.
    always_comb begin
        state_nxt  = state;
        start_pend = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_vld) begin
                    start_pend = 1'b1;
                    state_nxt  = ST_CONVERT;
                end else if (spectrum_valid) begin
                    state_nxt  = ST_CONVERT;
                end
            end
            ST_CONVERT: if (band_idx == 3'd7) state_nxt = ST_UPDATE;
            ST_UPDATE: begin
                if (pend_vld) begin
                    start_pend = 1'b1;
                    state_nxt  = ST_CONVERT;
                end else begin
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pend_wr = spectrum_valid && (busy || pend_vld);
    assign ovr_set = pend_wr && pend_vld && !start_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cap_q       <= '0;
            pend_q      <= '0;
            pend_vld    <= 1'b0;
            band_idx    <= '0;
            shadow_q    <= '0;
            lvl_q       <= '0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            update_done <= (state == ST_UPDATE);
            lvl_q       <= lvl_nxt;
            if (start_pend)
                cap_q <= pend_q;
            else if (state == ST_IDLE && spectrum_valid)
                cap_q <= spectrum_data_packed;
            if (pend_wr) begin
                pend_q   <= spectrum_data_packed;
                pend_vld <= 1'b1;
            end else if (start_pend) begin
                pend_vld <= 1'b0;
            end
            if (state == ST_CONVERT) begin
                shadow_q[band_idx] <= quantise(cap_q[band_idx]);
                band_idx           <= band_idx + 1'b1;
            end else begin
                band_idx <= '0;
            end
            if (ovr_set)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

`ifdef SPECTRUM_PEAK_HOLD_EN
    spectrum_peak_hold #(.DECAY_DIV(DECAY_DIV)) u_peak (
        .clk      (clk),
        .rst_n    (rst_n),
        .update   (state == ST_UPDATE),
        .lvl_nxt  (lvl_nxt),
        .peak_nxt (peak_nxt)
    );
`else
    assign peak_nxt = '0;
`endif

    assign col_nxt = (scan_cnt == SW'(SCAN_DIV - 1)) ? col_idx + 1'b1 : col_idx;

    // Pattern is built from next-cycle column/levels so row_data lines up with col_sel.
    always_comb begin
        row_nxt = '0;
        for (int r = 0; r < ROWS; r++)
            row_nxt[r] = (LEVEL_W'(r) < lvl_nxt[col_nxt]) ||
                         (peak_nxt[col_nxt] == LEVEL_W'(r + 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            col_idx  <= '0;
            row_data <= '0;
        end else begin
            scan_cnt <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
            col_idx  <= col_nxt;
            row_data <= row_nxt;
        end
    end

endmodule

// File: tb/tb_spectrum_bar_display.sv
// Directed bench for spectrum_bar_display: latency, quantisation, scan, overrun, reset, peak hold.
module tb_spectrum_bar_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] spectrum_data_packed;
    logic        spectrum_valid;
    logic        overrun_clr;
    logic [7:0]  col_sel, col_sel6;
    logic [15:0] row_data, row_data6;
    logic [39:0] levels_packed, levels_packed6;
    logic        update_done, update_done6, busy, busy6, overrun, overrun6;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    always #5 clk = ~clk;

    spectrum_bar_display #(.ROWS(16), .LEVEL_SHIFT(8), .SCAN_DIV(4), .DECAY_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .spectrum_data_packed(spectrum_data_packed),
        .spectrum_valid(spectrum_valid), .overrun_clr(overrun_clr),
        .col_sel(col_sel), .row_data(row_data), .levels_packed(levels_packed),
        .update_done(update_done), .busy(busy), .overrun(overrun)
    );

    spectrum_bar_display #(.ROWS(16), .LEVEL_SHIFT(6), .SCAN_DIV(4), .DECAY_DIV(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .spectrum_data_packed(spectrum_data_packed),
        .spectrum_valid(spectrum_valid), .overrun_clr(overrun_clr),
        .col_sel(col_sel6), .row_data(row_data6), .levels_packed(levels_packed6),
        .update_done(update_done6), .busy(busy6), .overrun(overrun6)
    );

    // Edges seen with reset released; drives the expected scan/decay phase.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= 0;
        else        cnt <= cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bar(input int l);
        return (l >= 16) ? 16'hFFFF : 16'((32'h1 << l) - 1);
    endfunction

    function automatic logic [95:0] rep12(input logic [11:0] v);
        return {8{v}};
    endfunction

    function automatic logic [39:0] rep5(input logic [4:0] v);
        return {8{v}};
    endfunction

    initial begin
        logic [7:0][11:0] dv;
        logic [7:0][4:0]  el, el6;
        int lv4 [8];
        int col, n_upd, n_busy, pm, lm;
        bit got;

        rst_n = 1'b0;
        spectrum_valid = 1'b0;
        spectrum_data_packed = '0;
        overrun_clr = 1'b0;
        tick();
        tick();
        chk("rst_col_sel", col_sel, 8'h01);
        chk("rst_row_data", row_data, 16'h0);
        chk("rst_levels", levels_packed, 40'h0);
        chk("rst_update_done", update_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;

        // Latency and quantisation ramp
        dv  = '{12'hFFF, 12'hC00, 12'h800, 12'h400, 12'h300, 12'h200, 12'h100, 12'h000};
        el  = '{5'd15, 5'd12, 5'd8, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        el6 = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd12, 5'd8, 5'd4, 5'd0};
        spectrum_data_packed = dv;
        spectrum_valid = 1'b1;
        n_busy = 0;
        for (int k = 0; k <= 10; k++) begin
            tick();
            spectrum_valid = 1'b0;
            if (busy) n_busy++;
            chk($sformatf("ramp_busy_k%0d", k), busy, (k <= 8));
            chk($sformatf("ramp_done_k%0d", k), update_done, (k == 9));
            chk($sformatf("ramp_levels_k%0d", k), levels_packed, (k >= 9) ? el : 40'h0);
            if (k == 9) begin
                chk("ramp_levels_shift6", levels_packed6, el6);
                chk("ramp_done_shift6", update_done6, 1'b1);
            end
        end
        chk("ramp_busy_cycles", n_busy, 9);
        chk("ramp_busy_shift6", busy6, 1'b0);

        // Overrun: 1st commits, 2nd lost, 3rd commits
        spectrum_data_packed = rep12(12'h100); spectrum_valid = 1'b1; tick();   // E0
        spectrum_valid = 1'b0; tick();                                          // E1
        spectrum_data_packed = rep12(12'h500); spectrum_valid = 1'b1; tick();   // E2
        spectrum_valid = 1'b0;
        chk("ovr_pending_no_overrun", overrun, 1'b0);
        tick();                                                                 // E3
        spectrum_data_packed = rep12(12'h900); spectrum_valid = 1'b1;
        overrun_clr = 1'b1; tick();                                             // E4
        spectrum_valid = 1'b0; overrun_clr = 1'b0;
        chk("ovr_set_beats_clr", overrun, 1'b1);
        repeat (5) tick();                                                      // E9
        chk("ovr_first_levels", levels_packed, rep5(5'd1));
        chk("ovr_first_done", update_done, 1'b1);
        repeat (8) tick();                                                      // E17
        chk("ovr_third_not_yet", levels_packed, rep5(5'd1));
        tick();                                                                 // E18
        chk("ovr_third_levels", levels_packed, rep5(5'd9));
        chk("ovr_third_done", update_done, 1'b1);
        tick();
        chk("ovr_idle_after", busy, 1'b0);
        chk("ovr_second_lost", levels_packed, rep5(5'd9));
        chk("ovr_sticky", overrun, 1'b1);
        chk("ovr_sticky_shift6", overrun6, 1'b1);
        overrun_clr = 1'b1; tick();
        overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);

        // Reset mid-conversion with a pending frame queued
        spectrum_data_packed = rep12(12'h300); spectrum_valid = 1'b1; tick();
        spectrum_valid = 1'b0; tick();
        spectrum_data_packed = rep12(12'h700); spectrum_valid = 1'b1; tick();
        spectrum_valid = 1'b0; tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_col_sel", col_sel, 8'h01);
        chk("midrst_row_data", row_data, 16'h0);
        chk("midrst_levels", levels_packed, 40'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_update_done", update_done, 1'b0);
        tick();
        rst_n = 1'b1;
        n_upd = 0; n_busy = 0;
        repeat (25) begin
            tick();
            if (update_done) n_upd++;
            if (busy) n_busy++;
        end
        chk("midrst_no_update", n_upd, 0);
        chk("midrst_no_busy", n_busy, 0);
        chk("midrst_levels_hold", levels_packed, 40'h0);

        // Scan rotation, per-column bar pattern, saturation on the shift-6 instance
        dv  = '{12'h700, 12'h600, 12'h500, 12'h400, 12'h300, 12'h200, 12'h100, 12'hFFF};
        lv4 = '{15, 1, 2, 3, 4, 5, 6, 7};
        spectrum_data_packed = dv; spectrum_valid = 1'b1; tick();
        spectrum_valid = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            col = (cnt / 4) % 8;
            chk($sformatf("scan_col_%0d", i), col_sel, 8'h01 << col);
            chk($sformatf("scan_col6_%0d", i), col_sel6, 8'h01 << col);
            chk($sformatf("scan_row_%0d", i), row_data, bar(lv4[col]));
            if (col == 0) chk($sformatf("sat_row6_%0d", i), row_data6, 16'hFFFF);
        end

`ifdef SPECTRUM_PEAK_HOLD_EN
        rst_n = 1'b0; #1; tick(); rst_n = 1'b1;
        spectrum_data_packed = rep12(12'hA00); spectrum_valid = 1'b1; tick();
        spectrum_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = update_done;
        end
        chk("peak_first_commit", got, 1'b1);
        spectrum_data_packed = rep12(12'h200); spectrum_valid = 1'b1; tick();
        spectrum_valid = 1'b0;
        pm = 10; lm = 10;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (update_done) lm = 2;
            if (cnt % 8 == 0 && pm > lm) pm--;
            chk($sformatf("peak_row_%0d", i), row_data, bar(lm) | ((pm > 0) ? 16'(32'h1 << (pm - 1)) : 16'h0));
        end
        chk("peak_final_row", row_data, 16'h0003);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
